fifo_write_ptr_full: RTL
========================

Name: fifo_write_ptr_full

Overview:
Write-domain pointer and full-flag generator for the async I2C FIFO. It feeds the FIFO memory block its write address and write-full qualifier. It also produces the Gray-coded write pointer that the read-domain synchronizer consumes. It takes the read pointer, already synchronized into the write domain, and derives full, almost-full, fill level and a sticky overflow flag.

Parameters:
addr_size, 4, memory address width; depth = 2^addr_size; pointers are addr_size+1 bits wide
almost_full_thresh, 12, fill level (0..2^addr_size) at or above which write_almost_full_o asserts

Ports:
write_clock_i  in  1  write-domain clock
write_reset_i  in  1  synchronous reset, active-high
write_en_i  in  1  write request from upstream producer
read_ptr_gray_sync_i  in  addr_size+1  read Gray pointer after 2-FF sync into write domain
write_addr_o  out  addr_size  memory write address (low bits of binary pointer)
write_ptr_gray_o  out  addr_size+1  registered Gray write pointer, to read-domain synchronizer
write_full_o  out  1  FIFO full; gates memory writes
write_almost_full_o  out  1  fill level >= almost_full_thresh
write_count_o  out  addr_size+1  fill level as seen from write domain, 0..2^addr_size
write_overflow_o  out  1  sticky: a write was attempted while full

Behaviour:
- One clock: write_clock_i. Reset is synchronous, active-high, on write_reset_i. All state updates on the posedge of write_clock_i.
- Reset: binary pointer, Gray pointer, write_count_o, write_full_o, write_almost_full_o and write_overflow_o all go to 0. write_addr_o therefore reads 0.
- Reset mid-operation: the FIFO is emptied from the write side only. Read-side reset is coordinated at system level and is out of scope here.
- Accept condition: push = write_en_i & ~write_full_o, using the registered full flag.
- Pointer update: wbin_next = wbin + push, wrapping modulo 2^(addr_size+1).
- Gray encoding: wgray_next = (wbin_next >> 1) ^ wbin_next. Both wbin and wgray are registered; no combinational path drives write_ptr_gray_o.
- write_addr_o = wbin[addr_size-1:0]. Memory captures data at the same edge that advances the pointer.
- Full flag (registered), computed from next-state values:
  - full_next = (wgray_next == {~rq[top:top-1], rq[top-2:0]}), where rq = read_ptr_gray_sync_i.
  - Full asserts on the edge that accepts the 2^addr_size-th outstanding word.
  - Full deasserts on the first edge after the synchronized read pointer moves.
- Read-pointer conversion: rbin = Gray-to-binary of read_ptr_gray_sync_i, combinational.
- Fill level: write_count_o <= wbin_next - rbin, modulo 2^(addr_size+1).
  - Latency: 1 cycle after a push or after a synced read-pointer change.
  - Range is 0..2^addr_size.
  - Because of sync delay, the count is conservative (over-estimates).
- Almost-full: write_almost_full_o <= (wbin_next - rbin) >= almost_full_thresh, registered in the same cycle as the count.
- Overflow: write_overflow_o <= write_overflow_o | (write_en_i & write_full_o). Cleared only by reset. A write rejected due to full does not alter pointers.
- Simultaneous write and synced read-pointer advance while full: the push is rejected because full is registered. Full then clears on that edge, and the next cycle's write is accepted.
- Wrap-around: pointer MSB toggles every 2^addr_size pushes. Full/empty distinction relies on this extra bit. Gray code changes exactly one bit per push.

Decomposition:
- Shared include file holds: the pointer-width localparam (addr_size+1), the depth localparam, and the bin-to-Gray function.
- One natural sub-module: fifo_gray2bin, a parameterized combinational XOR-prefix converter. It is reused by the read-side empty generator.

Test Plan:
- Reset: assert write_reset_i for 2 cycles with write_en_i=1 → write_addr_o=0, write_ptr_gray_o=0, write_count_o=0, all flags 0; no pointer movement during reset.
- Fill from empty: 16 consecutive writes, read pointer held at 0 → write_addr_o steps 0..15, then 0. write_full_o rises on the 16th accept edge; write_ptr_gray_o=5'b11000, write_count_o=16. write_almost_full_o rises on the edge after the 12th write.
- Write while full: a 17th write_en_i pulse → pointers unchanged, write_overflow_o=1 and stays 1 through later reads and writes until reset.
- Drain by one: with full set, change read_ptr_gray_sync_i from 0 to 5'b00001 → write_full_o=0 and write_count_o=15 one cycle later; the next write is accepted and full re-asserts.
- Wrap-around: 40 writes interleaved with read-pointer advances that keep the level between 2 and 5 → the binary pointer wraps through 31→0, each consecutive Gray value differs in exactly 1 bit, and write_full_o never asserts.
- Parameter sweep: addr_size=2, almost_full_thresh=3 → full after 4 writes; almost-full after 3 writes.

Source files
------------

// File: rtl/fifo_write_ptr_full_pkg.sv
// Shared definitions for the async FIFO pointer logic: default widths and the binary-to-Gray helper.
package fifo_write_ptr_full_pkg;
  localparam int addr_size_default = 4;
  localparam int ptr_w_default     = addr_size_default + 1;
  localparam int depth_default     = 1 << addr_size_default;
  localparam int gray_max_w        = 32;

  // Callers zero-extend their pointer in and keep only the low bits out.
  function automatic logic [gray_max_w-1:0] bin2gray(input logic [gray_max_w-1:0] b);
    return (b >> 1) ^ b;
  endfunction
endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter; bit i is the XOR of all Gray bits at or above i.
module fifo_gray2bin #(
  parameter int width = 5
) (
  input  logic [width-1:0] gray,
  output logic [width-1:0] bin
);
  always_comb begin
    bin = '0;
    for (int i = 0; i < width; i++) begin
      bin[i] = ^(gray >> i);
    end
  end
endmodule

// File: rtl/fifo_write_ptr_full.sv
// Write-side pointer, Gray pointer, full/almost-full, fill level and sticky overflow for the async FIFO.
// All outputs are registered; addr_size must be at least 2.
module fifo_write_ptr_full
  import fifo_write_ptr_full_pkg::*;
#(
  parameter int addr_size          = addr_size_default,
  parameter int almost_full_thresh = 12
) (
  input  logic                 write_clock_i,
  input  logic                 write_reset_i,
  input  logic                 write_en_i,
  input  logic [addr_size:0]   read_ptr_gray_sync_i,
  output logic [addr_size-1:0] write_addr_o,
  output logic [addr_size:0]   write_ptr_gray_o,
  output logic                 write_full_o,
  output logic                 write_almost_full_o,
  output logic [addr_size:0]   write_count_o,
  output logic                 write_overflow_o
);
  localparam int ptr_w = addr_size + 1;
  localparam logic [ptr_w-1:0] af_thresh = ptr_w'(almost_full_thresh);

  logic [ptr_w-1:0]            wbin;
  logic [ptr_w-1:0]            wbin_next;
  logic [ptr_w-1:0]            wgray_next;
  logic [ptr_w-1:0]            rbin;
  logic [ptr_w-1:0]            level_next;
  logic [ptr_w-1:0]            full_pattern;
  logic [gray_max_w-1:ptr_w]   gray_hi_unused;
  logic                        push;
  logic                        full_next;

  fifo_gray2bin #(.width(ptr_w)) u_rgray2bin (
    .gray (read_ptr_gray_sync_i),
    .bin  (rbin)
  );

  always_comb begin
    push       = write_en_i & ~write_full_o;
    wbin_next  = wbin + ptr_w'(push);
    {gray_hi_unused, wgray_next} = bin2gray(gray_max_w'(wbin_next));
    // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
    full_pattern = {~read_ptr_gray_sync_i[ptr_w-1:ptr_w-2], read_ptr_gray_sync_i[ptr_w-3:0]};
    full_next  = (wgray_next == full_pattern);
    level_next = wbin_next - rbin;
  end

  always_ff @(posedge write_clock_i) begin
    if (write_reset_i) begin
      wbin                <= '0;
      write_ptr_gray_o    <= '0;
      write_full_o        <= 1'b0;
      write_almost_full_o <= 1'b0;
      write_count_o       <= '0;
      write_overflow_o    <= 1'b0;
    end else begin
      wbin                <= wbin_next;
      write_ptr_gray_o    <= wgray_next;
      write_full_o        <= full_next;
      write_almost_full_o <= (level_next >= af_thresh);
      write_count_o       <= level_next;
      write_overflow_o    <= write_overflow_o | (write_en_i & write_full_o);
    end
  end

  assign write_addr_o = wbin[addr_size-1:0];
endmodule
